conv_channel_scheduler: RTL
===========================

Name: conv_channel_scheduler

Overview:
- Sequences the parallel convolution row array across multiple output channels for one conv layer.
- Per channel: reads the KERNEL_SIZE kernel columns from the weight/image buffer, then streams all IMAGE_SIZE image columns through the array.
- Tags each array result with channel and output column, and presents it downstream on a valid/ready handshake.
- Downstream backpressure freezes the whole pipeline (memory issue, array enable, tag pipe).

Parameters:
- KERNEL_SIZE, 5, kernel width/height in columns.
- IMAGE_SIZE, 28, input image width in columns.
- NUM_CH_MAX, 8, maximum output channels per layer.
- PIPE_LAT, 2, array latency in enabled cycles from arr_valid_in to a valid result.
- Derived OUT_COLS = IMAGE_SIZE-KERNEL_SIZE+1 (24). Stride is fixed at 1.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset: asynchronous, active-high.
- start, in, 1, begin a layer; sampled only in IDLE.
- cfg_num_ch, in, $clog2(NUM_CH_MAX)+1, channel count; sampled with start.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse at layer end.
- mem_rd_en, out, 1, buffer read strobe; data valid next cycle; buffer holds its output while mem_rd_en=0.
- mem_rd_sel, out, 1, 0 = kernel, 1 = image.
- mem_rd_ch, out, $clog2(NUM_CH_MAX), channel for kernel reads.
- mem_rd_col, out, $clog2(IMAGE_SIZE), column index.
- arr_en, out, 1, clock enable to the convolution array.
- arr_kernel_load, out, 1, registered mem_rd_en & ~mem_rd_sel.
- arr_valid_in, out, 1, registered mem_rd_en.
- out_valid, out, 1, array result valid.
- out_ready, in, 1, downstream accept.
- out_ch, out, $clog2(NUM_CH_MAX), channel tag of the current result.
- out_col, out, $clog2(OUT_COLS), output column tag.

Behaviour:
- Reset (async, any state): state=IDLE, ch/col counters=0, tag pipe cleared. All outputs 0 except arr_en=1.
- stall = out_valid & ~out_ready. While stall:
  - mem_rd_en=0 and arr_en=0.
  - Counters, state, arr_kernel_load, arr_valid_in and the tag pipe all hold.
- States:
  - IDLE: on start, latch cfg_num_ch. Go to DONE if it is 0, else to LOAD_K with ch=0.
  - LOAD_K: mem_rd_en=1, sel=0, col 0..KERNEL_SIZE-1 on consecutive unstalled cycles. After col KERNEL_SIZE-1 go to STREAM with col=0.
  - STREAM: mem_rd_en=1, sel=1, col 0..IMAGE_SIZE-1. After col IMAGE_SIZE-1 go to DRAIN.
  - DRAIN: no reads. When the tag pipe is empty and out_valid=0 (or is being accepted this cycle), go to DONE if ch==num_ch-1, else ch+1 and LOAD_K.
  - DONE: done=1 for one cycle, then IDLE.
- Tag pipe:
  - An image column c with c >= KERNEL_SIZE-1 enters the pipe alongside arr_valid_in, tagged (ch, c-(KERNEL_SIZE-1)).
  - The tag advances only when arr_en=1.
  - out_valid rises PIPE_LAT enabled cycles after the matching arr_valid_in.
  - out_valid, out_ch and out_col hold until out_ready.
- Timing, no stall (start sampled at cycle 0):
  - Kernel reads in cycles 1..5; image col c read at cycle 6+c.
  - First out_valid at cycle 13 (col 0); last at cycle 36 (col 23).
  - done at cycle 38, i.e. 2 cycles after the final handshake.
- Channels: the next channel's LOAD_K begins only after the previous channel fully drains. There is no overlap between channels.
- start while busy is ignored. cfg_num_ch > NUM_CH_MAX is clamped to NUM_CH_MAX.
- Reset asserted mid-stream: no further out_valid and no done pulse; a new start runs cleanly.

Test Plan:
- cfg_num_ch=1, out_ready=1, start at cycle 0:
  - mem_rd_en high cycles 1..33.
  - Kernel cols 0..4 read, then image cols 0..27.
  - out_valid on cycles 13..36 with out_col 0..23.
  - done only at cycle 38.
- cfg_num_ch=3, out_ready=1:
  - 72 results, out_ch 0,0..,1,..,2 in order.
  - Each LOAD_K reads with mem_rd_ch equal to the channel.
  - Exactly one done pulse.
- out_ready=0 for cycles 15..19 (single channel):
  - out_valid/out_col (=2) held stable and mem_rd_en=0 throughout.
  - arr_en=0 throughout; no column lost or duplicated; done shifts to cycle 43.
- cfg_num_ch=0:
  - done pulses 2 cycles after start.
  - No mem_rd_en and no out_valid.
- Reset asserted at cycle 20, then start at cycle 25:
  - Outputs return to reset values immediately.
  - The second run reproduces the first scenario's sequence offset by 25 cycles.
- start pulsed again at cycle 10 during a run: ignored, with an identical result stream and a single done.

Source files
------------

// File: rtl/conv_channel_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_channel_scheduler_if
// Purpose  : Control, buffer-read, array and result handshake bundle.
// Revision : 1.0
// ============================================================================
interface conv_channel_scheduler_if #(
  parameter int KERNEL_SIZE = 5,
  parameter int IMAGE_SIZE  = 28,
  parameter int NUM_CH_MAX  = 8
);
  localparam int CH_W   = $clog2(NUM_CH_MAX);
  localparam int COL_W  = $clog2(IMAGE_SIZE);
  localparam int OCOL_W = $clog2(IMAGE_SIZE - KERNEL_SIZE + 1);

  logic              start;
  logic [CH_W:0]     cfg_num_ch;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic              mem_rd_sel;
  logic [CH_W-1:0]   mem_rd_ch;
  logic [COL_W-1:0]  mem_rd_col;
  logic              arr_en;
  logic              arr_kernel_load;
  logic              arr_valid_in;
  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic [OCOL_W-1:0] out_col;

  modport master (
    input  start, cfg_num_ch, out_ready,
    output busy, done, mem_rd_en, mem_rd_sel, mem_rd_ch, mem_rd_col,
           arr_en, arr_kernel_load, arr_valid_in, out_valid, out_ch, out_col
  );

  modport slave (
    output start, cfg_num_ch, out_ready,
    input  busy, done, mem_rd_en, mem_rd_sel, mem_rd_ch, mem_rd_col,
           arr_en, arr_kernel_load, arr_valid_in, out_valid, out_ch, out_col
  );
endinterface
`default_nettype wire

// File: rtl/conv_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : conv_channel_scheduler
// Purpose  : Sequences kernel load and image streaming per output channel,
//            tags array results and presents them on a valid/ready port.
// Revision : 1.0
// ============================================================================
module conv_channel_scheduler #(
  parameter int KERNEL_SIZE = 5,
  parameter int IMAGE_SIZE  = 28,
  parameter int NUM_CH_MAX  = 8,
  parameter int PIPE_LAT    = 2
) (
  input logic                       clk,
  input logic                       rst,
  conv_channel_scheduler_if.master  bus
);
  localparam int OUT_COLS = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int CH_W     = $clog2(NUM_CH_MAX);
  localparam int COL_W    = $clog2(IMAGE_SIZE);
  localparam int OCOL_W   = $clog2(OUT_COLS);
  localparam logic [COL_W-1:0] K_LAST  = COL_W'(KERNEL_SIZE - 1);
  localparam logic [COL_W-1:0] I_LAST  = COL_W'(IMAGE_SIZE - 1);
  localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);
  localparam logic [CH_W-1:0]  CH_ONE  = CH_W'(1);
  localparam logic [CH_W:0]    NUM_ONE = (CH_W+1)'(1);
  localparam logic [CH_W:0]    CH_CAP  = (CH_W+1)'(NUM_CH_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_K = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [CH_W:0]     num_q, num_d;
  logic              kload_q, vin_q, done_q;
  logic [PIPE_LAT-1:0] tv_q;
  logic [CH_W-1:0]   tch_q  [PIPE_LAT];
  logic [OCOL_W-1:0] tcol_q [PIPE_LAT];
  logic              ov_q;
  logic [CH_W-1:0]   och_q;
  logic [OCOL_W-1:0] ocol_q;

  logic              stall, rd_en, rd_sel, tag_in, last_ch;
  logic [CH_W:0]     cfg_clamped;

  assign stall       = ov_q & ~bus.out_ready;
  assign cfg_clamped = (bus.cfg_num_ch > CH_CAP) ? CH_CAP : bus.cfg_num_ch;
  assign last_ch     = ({1'b0, ch_q} == (num_q - NUM_ONE));
  // Only image columns that complete a full kernel window produce a result
  assign tag_in      = rd_en & rd_sel & (col_q >= K_LAST);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    col_d   = col_q;
    num_d   = num_q;
    rd_en   = 1'b0;
    rd_sel  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          num_d   = cfg_clamped;
          ch_d    = '0;
          col_d   = '0;
          state_d = (cfg_clamped == '0) ? S_DONE : S_LOAD_K;
        end
      end
      S_LOAD_K: begin
        rd_en = ~stall;
        if (!stall) begin
          if (col_q == K_LAST) begin
            col_d   = '0;
            state_d = S_STREAM;
          end else begin
            col_d = col_q + COL_ONE;
          end
        end
      end
      S_STREAM: begin
        rd_en  = ~stall;
        rd_sel = 1'b1;
        if (!stall) begin
          if (col_q == I_LAST) begin
            col_d   = '0;
            state_d = S_DRAIN;
          end else begin
            col_d = col_q + COL_ONE;
          end
        end
      end
      S_DRAIN: begin
        if ((tv_q == '0) && (!ov_q || bus.out_ready)) begin
          if (last_ch) begin
            state_d = S_DONE;
          end else begin
            ch_d    = ch_q + CH_ONE;
            state_d = S_LOAD_K;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      col_q   <= '0;
      num_q   <= '0;
      done_q  <= 1'b0;
      kload_q <= 1'b0;
      vin_q   <= 1'b0;
      tv_q    <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        tch_q[i]  <= '0;
        tcol_q[i] <= '0;
      end
      ov_q    <= 1'b0;
      och_q   <= '0;
      ocol_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      col_q   <= col_d;
      num_q   <= num_d;
      done_q  <= (state_q == S_DONE);
      // Backpressure freezes array strobes and every tag stage together
      if (!stall) begin
        kload_q   <= rd_en & ~rd_sel;
        vin_q     <= rd_en;
        tv_q[0]   <= tag_in;
        tch_q[0]  <= ch_q;
        tcol_q[0] <= OCOL_W'(col_q - K_LAST);
        for (int i = 1; i < PIPE_LAT; i++) begin
          tv_q[i]   <= tv_q[i-1];
          tch_q[i]  <= tch_q[i-1];
          tcol_q[i] <= tcol_q[i-1];
        end
        ov_q   <= tv_q[PIPE_LAT-1];
        och_q  <= tch_q[PIPE_LAT-1];
        ocol_q <= tcol_q[PIPE_LAT-1];
      end
    end
  end

  assign bus.busy            = (state_q != S_IDLE);
  assign bus.done            = done_q;
  assign bus.mem_rd_en       = rd_en;
  assign bus.mem_rd_sel      = rd_sel;
  assign bus.mem_rd_ch       = ch_q;
  assign bus.mem_rd_col      = col_q;
  assign bus.arr_en          = ~stall;
  assign bus.arr_kernel_load = kload_q;
  assign bus.arr_valid_in    = vin_q;
  assign bus.out_valid       = ov_q;
  assign bus.out_ch          = och_q;
  assign bus.out_col         = ocol_q;
endmodule
`default_nettype wire
